// File: rtl/down_count_checker.sv
// rtl/down_count_checker.sv - lock-and-track monitor for a free-running down counter
module down_count_checker #(
    parameter int WIDTH      = 16,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8,
    parameter int SLIP_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_valid,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clear,
    output logic              locked,
    output logic              tc_pulse,
    output logic              wrap_pulse,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  last_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, SLIP} state_t;

    localparam logic [3:0]        SLIP_MAX = 4'(SLIP_LIMIT);
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    state_t     state_q, state_d;
    logic [3:0] slip_q, slip_d;
    logic [3:0] slip_inc;
    logic       accept;
    logic       pass;
    logic       tc_d, wrap_d, mism_d;

    assign accept   = cnt_valid && !clear;
    // Modulo arithmetic makes 0 -> all-ones a legal decrement.
    assign pass     = (cnt_in == (last_cnt - CNT_ONE));
    assign slip_inc = slip_q + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            slip_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slip_d  = slip_q;
        if (clear) begin
            state_d = IDLE;
            slip_d  = 4'd0;
        end else if (cnt_valid) begin
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (pass) state_d = TRACK;
                end
                TRACK: begin
                    if (!pass) begin
                        if (SLIP_MAX == 4'd1) begin
                            state_d = ACQ;
                            slip_d  = 4'd0;
                        end else begin
                            state_d = SLIP;
                            slip_d  = 4'd1;
                        end
                    end
                end
                SLIP: begin
                    if (pass) begin
                        state_d = TRACK;
                        slip_d  = 4'd0;
                    end else if (slip_inc == SLIP_MAX) begin
                        state_d = ACQ;
                        slip_d  = 4'd0;
                    end else begin
                        slip_d  = slip_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tc_d   = 1'b0;
        wrap_d = 1'b0;
        mism_d = 1'b0;
        if (accept) begin
            case (state_q)
                ACQ, TRACK, SLIP: begin
                    tc_d   = pass && (cnt_in == '0);
                    wrap_d = pass && (cnt_in == '1);
                    mism_d = !pass && (state_q != ACQ);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked     <= 1'b0;
            tc_pulse   <= 1'b0;
            wrap_pulse <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            last_cnt   <= '1;
        end else if (clear) begin
            locked     <= 1'b0;
            tc_pulse   <= 1'b0;
            wrap_pulse <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            last_cnt   <= '1;
        end else begin
            locked     <= (state_d == TRACK) || (state_d == SLIP);
            tc_pulse   <= tc_d;
            wrap_pulse <= wrap_d;
            mismatch   <= mism_d;
            if (cnt_valid) last_cnt <= cnt_in;
            if (mism_d) begin
                err_sticky <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_ONE;
            end
            if (wrap_d && (wrap_count != '1)) wrap_count <= wrap_count + WRAP_ONE;
        end
    end

endmodule

// File: tb/tb_down_count_checker.sv
// tb/tb_down_count_checker.sv - directed and randomized checks against a behavioural model
module tb_down_count_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cnt_valid = 1'b0;
    logic [15:0] cnt_in = 16'h0;
    logic        clear = 1'b0;

    logic        locked0, tc0, wrap0, mism0, sticky0;
    logic [7:0]  errc0, wrapc0;
    logic [15:0] last0;
    logic        locked1, tc1, wrap1, mism1, sticky1;
    logic [1:0]  errc1, wrapc1;
    logic [15:0] last1;

    int checks = 0;
    int failures = 0;

    down_count_checker #(.WIDTH(16), .ERR_W(8), .WRAP_W(8), .SLIP_LIMIT(3)) dut0 (
        .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clear(clear),
        .locked(locked0), .tc_pulse(tc0), .wrap_pulse(wrap0), .mismatch(mism0),
        .err_sticky(sticky0), .err_count(errc0), .wrap_count(wrapc0), .last_cnt(last0));

    down_count_checker #(.WIDTH(16), .ERR_W(2), .WRAP_W(2), .SLIP_LIMIT(1)) dut1 (
        .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clear(clear),
        .locked(locked1), .tc_pulse(tc1), .wrap_pulse(wrap1), .mismatch(mism1),
        .err_sticky(sticky1), .err_count(errc1), .wrap_count(wrapc1), .last_cnt(last1));

    always #5 clk = ~clk;

    // Reference model: "seen" = a sample has been taken since reset, "lock" = tracking.
    int p_lim  [2] = '{3, 1};
    int p_emax [2] = '{255, 3};
    int p_wmax [2] = '{255, 3};
    int m_seen [2], m_lock [2], m_slip [2], m_err [2], m_wrap [2];
    int m_sticky [2], m_last [2], m_tc [2], m_wp [2], m_mm [2];

    task automatic model_reset(input int i);
        m_seen[i] = 0; m_lock[i] = 0; m_slip[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
        m_sticky[i] = 0; m_last[i] = 65535; m_tc[i] = 0; m_wp[i] = 0; m_mm[i] = 0;
    endtask

    task automatic model_step(input int i, input bit v, input bit c, input int x);
        bit ok;
        m_tc[i] = 0; m_wp[i] = 0; m_mm[i] = 0;
        if (c) begin
            model_reset(i);
        end else if (v) begin
            ok = (x == ((m_last[i] + 65535) % 65536));
            if (m_seen[i] == 0) begin
                m_seen[i] = 1;
            end else if (ok) begin
                m_lock[i] = 1;
                m_slip[i] = 0;
                m_tc[i] = (x == 0) ? 1 : 0;
                m_wp[i] = (x == 65535) ? 1 : 0;
                if (m_wp[i] == 1 && m_wrap[i] < p_wmax[i]) m_wrap[i]++;
            end else if (m_lock[i] == 1) begin
                m_mm[i] = 1;
                m_sticky[i] = 1;
                if (m_err[i] < p_emax[i]) m_err[i]++;
                m_slip[i]++;
                if (m_slip[i] >= p_lim[i]) begin
                    m_lock[i] = 0;
                    m_slip[i] = 0;
                end
            end
            m_last[i] = x;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("d0.locked", 32'(locked0), m_lock[0]);
        check("d0.tc",     32'(tc0),     m_tc[0]);
        check("d0.wrap",   32'(wrap0),   m_wp[0]);
        check("d0.mism",   32'(mism0),   m_mm[0]);
        check("d0.sticky", 32'(sticky0), m_sticky[0]);
        check("d0.errc",   32'(errc0),   m_err[0]);
        check("d0.wrapc",  32'(wrapc0),  m_wrap[0]);
        check("d0.last",   32'(last0),   m_last[0]);
        check("d1.locked", 32'(locked1), m_lock[1]);
        check("d1.tc",     32'(tc1),     m_tc[1]);
        check("d1.wrap",   32'(wrap1),   m_wp[1]);
        check("d1.mism",   32'(mism1),   m_mm[1]);
        check("d1.sticky", 32'(sticky1), m_sticky[1]);
        check("d1.errc",   32'(errc1),   m_err[1]);
        check("d1.wrapc",  32'(wrapc1),  m_wrap[1]);
        check("d1.last",   32'(last1),   m_last[1]);
    endtask

    task automatic cyc(input bit v, input bit c, input int x);
        cnt_valid = v;
        clear = c;
        cnt_in = 16'(x);
        @(posedge clk);
        model_step(0, v, c, x);
        model_step(1, v, c, x);
        #1 compare_all();
    endtask

    initial begin
        int cur;
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1 compare_all();
        reset = 1'b1;

        cyc(1, 0, 16'hFFFF);
        cyc(1, 0, 16'hFFFE);
        check("tp1.locked", 32'(locked0), 1);
        cyc(1, 0, 16'hFFFD);
        check("tp1.errc", 32'(errc0), 0);

        cyc(0, 1, 0);
        cyc(1, 0, 16'h0004);
        cyc(1, 0, 16'h0003);
        cyc(1, 0, 16'h0002);
        cyc(1, 0, 16'h0001);
        cyc(1, 0, 16'h0000);
        check("tp2.tc", 32'(tc0), 1);
        cyc(1, 0, 16'hFFFF);
        check("tp2.wrap", 32'(wrap0), 1);
        cyc(1, 0, 16'hFFFE);
        check("tp2.wrapc", 32'(wrapc0), 1);
        check("tp2.last", 32'(last0), 32'hFFFE);

        cyc(0, 1, 0);
        cyc(1, 0, 16'h0101);
        cyc(1, 0, 16'h0100);
        cyc(1, 0, 16'h0050);
        check("tp3.mism", 32'(mism0), 1);
        cyc(1, 0, 16'h004F);
        check("tp3.locked", 32'(locked0), 1);
        check("tp3.errc", 32'(errc0), 1);

        cyc(0, 1, 0);
        cyc(1, 0, 16'h1001);
        cyc(1, 0, 16'h1000);
        cyc(1, 0, 16'h0AAA);
        cyc(1, 0, 16'h0555);
        cyc(1, 0, 16'h0123);
        check("tp4.unlock", 32'(locked0), 0);
        check("tp4.errc", 32'(errc0), 3);
        cyc(1, 0, 16'h0122);
        check("tp4.relock", 32'(locked0), 1);

        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 16'h2000 + k * 16);
            cyc(1, 0, 16'h2000 + k * 16 - 1);
            cyc(1, 0, 16'h7000 + k);
        end
        check("tp5.sat", 32'(errc1), 3);
        cyc(1, 1, 16'h1234);
        check("tp5.clr_last", 32'(last1), 32'hFFFF);

        cyc(1, 0, 16'h0012);
        cyc(1, 0, 16'h0011);
        cyc(1, 0, 16'h0010);
        repeat (3) cyc(0, 0, 16'h5555);
        cyc(1, 0, 16'h000F);
        check("tp6.gap", 32'(mism0), 0);

        #2 reset = 1'b0;
        model_reset(0);
        model_reset(1);
        #1 compare_all();
        #1 reset = 1'b1;

        cur = 16'hFFFF;
        for (int n = 0; n < 3000; n++) begin
            bit v, c;
            int r;
            r = int'($urandom_range(0, 127));
            v = ($urandom_range(0, 3) != 0);
            c = (r == 0);
            if (r < 6) cur = int'($urandom_range(0, 65535));
            else if (r < 9) cur = int'($urandom_range(0, 3));
            cyc(v, c, cur);
            if (v) cur = (cur + 65535) % 65536;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
